inst_fetch: RTL and testbench

- Program-counter/fetch sequencer that drives the 11-bit instruction address into the instruction ROM.
- Launches one of three resident programs on a Start pulse and steps the PC each cycle.
- Applies relative branches and LUT-based absolute jumps requested by the decoder.
- Holds on stall, and reports Done on halt to the top-level test harness.

---
 rtl/inst_fetch_pkg.sv | 48 ++++
 rtl/inst_fetch_if.sv | 44 ++++
 rtl/inst_fetch_jump_lut.sv | 17 +
 rtl/inst_fetch.sv | 103 ++++++++++
 tb/tb_inst_fetch.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer (package fetch_pkg).
// Optional feature macro: FETCH_INST_COUNT_EN (adds a 16-bit executed-instruction counter).
package fetch_pkg;

  localparam int ADDR_W    = 11;
  localparam int LUT_DEPTH = 32;
  localparam int JIDX_W    = 5;
  localparam int OFF_W     = 8;
  localparam int CNT_W     = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [JIDX_W-1:0] jidx_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam addr_t PROG0_BASE = 11'd0;
  localparam addr_t PROG1_BASE = 11'd512;
  localparam addr_t PROG2_BASE = 11'd1024;

  // Absolute jump targets; entry 0 is listed first.
  localparam addr_t JUMP_LUT [LUT_DEPTH] = '{
    11'd0,    11'd16,   11'd32,   11'd600,  11'd64,   11'd80,   11'd96,   11'd2000,
    11'd128,  11'd700,  11'd160,  11'd176,  11'd192,  11'd208,  11'd224,  11'd240,
    11'd256,  11'd272,  11'd288,  11'd304,  11'd320,  11'd336,  11'd352,  11'd368,
    11'd384,  11'd400,  11'd416,  11'd432,  11'd448,  11'd464,  11'd480,  11'd2047
  };

  // Entry address for a program select; select 3 is never launched, so 0 is a don't-care.
  function automatic addr_t prog_base(input logic [1:0] sel);
    case (sel)
      2'd0:    prog_base = PROG0_BASE;
      2'd1:    prog_base = PROG1_BASE;
      2'd2:    prog_base = PROG2_BASE;
      default: prog_base = PROG0_BASE;
    endcase
  endfunction

  // Sign-extend an instruction offset to address width (two's complement add wraps).
  function automatic addr_t sext_offset(input logic [OFF_W-1:0] off);
    sext_offset = {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Decoder/harness <-> fetch sequencer signal bundle.
// Optional feature macro: FETCH_INST_COUNT_EN (adds InstCount).
//
// Handshake: Start is a one-cycle request sampled on the rising clock edge together
// with ProgSel; it is accepted only in IDLE/DONE with ProgSel < 3 and is otherwise
// dropped without acknowledge. Halt/Stall/BranchEn are level qualifiers evaluated
// against the InstAddress currently presented and act only while Running is high.
interface inst_fetch_if;
  import fetch_pkg::*;

  logic              Start;
  logic [1:0]        ProgSel;
  logic              Halt;
  logic              Stall;
  logic              BranchEn;
  logic              BranchRel;
  logic [OFF_W-1:0]  BranchOffset;
  jidx_t             JumpIdx;
  addr_t             InstAddress;
  logic              Running;
  logic              Done;
`ifdef FETCH_INST_COUNT_EN
  cnt_t              InstCount;
`endif

  // Decoder / harness side
  modport master (
    output Start, ProgSel, Halt, Stall, BranchEn, BranchRel, BranchOffset, JumpIdx,
`ifdef FETCH_INST_COUNT_EN
    input  InstCount,
`endif
    input  InstAddress, Running, Done
  );

  // Fetch sequencer side
  modport slave (
    input  Start, ProgSel, Halt, Stall, BranchEn, BranchRel, BranchOffset, JumpIdx,
`ifdef FETCH_INST_COUNT_EN
    output InstCount,
`endif
    output InstAddress, Running, Done
  );

endinterface

// File: rtl/inst_fetch_jump_lut.sv
// Combinational jump-table lookup: index -> absolute target. Out-of-range index yields 0.
module jump_lut
  import fetch_pkg::*;
(
  input  jidx_t idx,
  output addr_t target
);

  // Table read with range guard so a deeper index field cannot read past the table.
  always_comb begin
    target = '0;
    if ({1'b0, idx} < (JIDX_W+1)'(LUT_DEPTH)) begin
      target = JUMP_LUT[idx];
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Program counter / fetch sequencer: launches a resident program on Start, steps the PC,
// applies relative branches and table jumps, holds on stall, reports Done on halt.
// Optional feature macro: FETCH_INST_COUNT_EN (saturating count of non-stalled RUN cycles).
module inst_fetch
  import fetch_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  inst_fetch_if.slave       bus,
  output state_e            dbg_state
);

  state_e state_q, state_d;
  addr_t  pc_q, pc_d;
  logic   running_q, running_d;
  logic   done_q, done_d;
  addr_t  jump_target;
  logic   start_ok;

  jump_lut u_jump_lut (
    .idx    (bus.JumpIdx),
    .target (jump_target)
  );

  assign start_ok = bus.Start && (bus.ProgSel != 2'd3);

  // Next-state and next-PC selection; priority in RUN is Halt > Stall > BranchEn > increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d = RUN;
          pc_d    = prog_base(bus.ProgSel);
        end
      end
      RUN: begin
        if (bus.Halt) begin
          state_d = DONE;
        end else if (bus.Stall) begin
          pc_d = pc_q;
        end else if (bus.BranchEn) begin
          pc_d = bus.BranchRel ? (pc_q + sext_offset(bus.BranchOffset)) : jump_target;
        end else begin
          pc_d = pc_q + addr_t'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // State, PC and status flags; reset aborts at once without producing Done.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.InstAddress = pc_q;
  assign bus.Running     = running_q;
  assign bus.Done        = done_q;
  assign dbg_state       = state_q;

`ifdef FETCH_INST_COUNT_EN
  cnt_t count_q, count_d;

  // Cleared on accepted launch; counts RUN cycles that retire (halt cycle included), saturating.
  always_comb begin
    count_d = count_q;
    if ((state_q != RUN) && start_ok) begin
      count_d = '0;
    end else if ((state_q == RUN) && (bus.Halt || !bus.Stall) && (count_q != '1)) begin
      count_d = count_q + cnt_t'(1);
    end
  end

  // Counter register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.InstCount = count_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset checks, a table of per-cycle vectors, and
// hand-written sequences for async reset and the optional instruction counter.
module tb_inst_fetch;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  inst_fetch_if bus();

  inst_fetch dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // ---------------- vector table ----------------
  typedef struct {
    logic       start;
    logic [1:0] sel;
    logic       halt;
    logic       stall;
    logic       br_en;
    logic       br_rel;
    logic [7:0] off;
    logic [4:0] jidx;
    int         exp_pc;
    logic       exp_run;
    logic       exp_done;
    state_e     exp_state;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.Start        = 1'b0;
    bus.ProgSel      = 2'd0;
    bus.Halt         = 1'b0;
    bus.Stall        = 1'b0;
    bus.BranchEn     = 1'b0;
    bus.BranchRel    = 1'b0;
    bus.BranchOffset = 8'd0;
    bus.JumpIdx      = 5'd0;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.Start        = v.start;
    bus.ProgSel      = v.sel;
    bus.Halt         = v.halt;
    bus.Stall        = v.stall;
    bus.BranchEn     = v.br_en;
    bus.BranchRel    = v.br_rel;
    bus.BranchOffset = v.off;
    bus.JumpIdx      = v.jidx;
  endtask

  // Advance one edge and land 1 time unit after it, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input int pc, input logic run,
                              input logic done, input state_e st);
    check({tag, " pc"},    int'(bus.InstAddress), pc);
    check({tag, " run"},   int'(bus.Running),     int'(run));
    check({tag, " done"},  int'(bus.Done),        int'(done));
    check({tag, " state"}, int'(dbg_state),       int'(st));
  endtask

  function automatic vec_t mk(input logic start, input logic [1:0] sel, input logic halt,
                              input logic stall, input logic br_en, input logic br_rel,
                              input logic [7:0] off, input logic [4:0] jidx, input int pc,
                              input logic run, input logic done, input state_e st);
    vec_t v;
    v.start = start; v.sel = sel; v.halt = halt; v.stall = stall;
    v.br_en = br_en; v.br_rel = br_rel; v.off = off; v.jidx = jidx;
    v.exp_pc = pc; v.exp_run = run; v.exp_done = done; v.exp_state = st;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    checks = 0;
    errors = 0;

    // Expected targets for this table: JUMP_LUT[3]=600, [7]=2000, [9]=700, [31]=2047.
    //          st  sel  hlt stl ben rel off     jidx   pc    run  done state
    vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0, 8'h00, 5'd0,  512,  1, 0, RUN));  // launch prog 1
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 0, 8'h00, 5'd0,  513,  1, 0, RUN));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 0, 8'h00, 5'd0,  514,  1, 0, RUN));
    vecs.push_back(mk(1, 2'd0, 0, 0, 0, 0, 8'h00, 5'd0,  515,  1, 0, RUN));  // Start in RUN ignored
    vecs.push_back(mk(0, 2'd0, 0, 0, 1, 0, 8'h00, 5'd3,  600,  1, 0, RUN));  // table jump idx 3
    vecs.push_back(mk(0, 2'd0, 0, 0, 1, 1, 8'hFC, 5'd0,  596,  1, 0, RUN));  // -4
    vecs.push_back(mk(0, 2'd0, 0, 1, 1, 0, 8'h00, 5'd3,  596,  1, 0, RUN));  // stalled jump
    vecs.push_back(mk(0, 2'd0, 0, 0, 1, 0, 8'h00, 5'd7,  2000, 1, 0, RUN));
    vecs.push_back(mk(0, 2'd0, 0, 0, 1, 1, 8'h7F, 5'd0,  79,   1, 0, RUN));  // +127 wraps
    vecs.push_back(mk(0, 2'd0, 0, 0, 1, 0, 8'h00, 5'd31, 2047, 1, 0, RUN));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 0, 8'h00, 5'd0,  0,    1, 0, RUN));  // 2047 -> 0
    vecs.push_back(mk(0, 2'd0, 0, 0, 1, 0, 8'h00, 5'd9,  700,  1, 0, RUN));
    vecs.push_back(mk(0, 2'd0, 1, 1, 1, 1, 8'h01, 5'd0,  700,  0, 1, DONE)); // halt wins
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 0, 8'h00, 5'd0,  700,  0, 1, DONE)); // DONE holds
    vecs.push_back(mk(0, 2'd0, 1, 1, 1, 1, 8'h05, 5'd3,  700,  0, 1, DONE)); // ignored outside RUN
    vecs.push_back(mk(1, 2'd3, 0, 0, 0, 0, 8'h00, 5'd0,  700,  0, 1, DONE)); // ProgSel 3 ignored
    vecs.push_back(mk(1, 2'd2, 0, 0, 0, 0, 8'h00, 5'd0,  1024, 1, 0, RUN));  // relaunch prog 2
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 0, 8'h00, 5'd0,  1025, 1, 0, RUN));

    // Reset state
    drive_idle();
    rst_n = 1'b0;
    step();
    step();
    check_status("reset", 0, 1'b0, 1'b0, IDLE);
    rst_n = 1'b1;
    step();

    // Start with ProgSel=3 from IDLE stays IDLE at PC 0
    bus.Start   = 1'b1;
    bus.ProgSel = 2'd3;
    step();
    check_status("sel3_idle", 0, 1'b0, 1'b0, IDLE);
    drive_idle();
    step();

    // Table-driven run
    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      step();
      check_status($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_run,
                   vecs[i].exp_done, vecs[i].exp_state);
    end
    drive_idle();

    // Async reset mid-RUN at PC 40 clears without a clock edge
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    bus.Start   = 1'b1;
    bus.ProgSel = 2'd0;
    step();
    drive_idle();
    bus.BranchEn     = 1'b1;
    bus.BranchRel    = 1'b1;
    bus.BranchOffset = 8'd40;
    step();
    drive_idle();
    check_status("pre_reset", 40, 1'b1, 1'b0, RUN);
    #2;
    rst_n = 1'b0;
    #1;
    check_status("async_reset", 0, 1'b0, 1'b0, IDLE);
    #1;
    rst_n = 1'b1;
    step();
    check_status("after_reset", 0, 1'b0, 1'b0, IDLE);

`ifdef FETCH_INST_COUNT_EN
    // 10 retired instructions, 2 stalls, then halt -> 11
    bus.Start   = 1'b1;
    bus.ProgSel = 2'd0;
    step();
    drive_idle();
    check("cnt_launch", int'(bus.InstCount), 0);
    for (int i = 0; i < 10; i++) step();
    check("cnt_ten", int'(bus.InstCount), 10);
    bus.Stall = 1'b1;
    step();
    step();
    check("cnt_stall", int'(bus.InstCount), 10);
    bus.Stall = 1'b0;
    bus.Halt  = 1'b1;
    step();
    drive_idle();
    check("cnt_halt", int'(bus.InstCount), 11);
    check_status("cnt_done", 10, 1'b0, 1'b1, DONE);
    step();
    step();
    check("cnt_hold", int'(bus.InstCount), 11);
    bus.Start   = 1'b1;
    bus.ProgSel = 2'd1;
    step();
    drive_idle();
    check("cnt_clear", int'(bus.InstCount), 0);
    check_status("cnt_relaunch", 512, 1'b1, 1'b0, RUN);
    step();
    check("cnt_first", int'(bus.InstCount), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
